div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 99 +++++++++
 tb/tb_div_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle restoring divider controller for DIV/DIVU with pipeline stall/annul
module div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        annul,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] quo, dvs, rem;
    logic [5:0]  cnt;
    logic        neg_q, neg_r;
    logic        accept;
    logic [31:0] abs_a, abs_b;
    logic [32:0] rem_shift;
    logic [33:0] diff;
    logic        q_bit;
    logic [31:0] rem_next, quo_next;
    logic        diff_unused;

    // quo doubles as the dividend shifter: its MSB feeds the remainder, quotient bits enter at the LSB
    always_comb begin
        abs_a       = (sign && a[31]) ? (~a + 32'd1) : a;
        abs_b       = (sign && b[31]) ? (~b + 32'd1) : b;
        accept      = resetn && start && !annul && (state == IDLE || state == DONE);
        rem_shift   = {rem, quo[31]};
        diff        = {1'b0, rem_shift} - {2'b00, dvs};
        q_bit       = ~diff[33];
        rem_next    = q_bit ? diff[31:0] : rem_shift[31:0];
        quo_next    = {quo[30:0], q_bit};
        diff_unused = diff[32];
    end

    always_comb begin
        state_next = state;
        stall      = accept || (state == BUSY && !annul);
        done       = (state == DONE);
        case (state)
            IDLE: if (accept) state_next = (b == 32'd0) ? DONE : BUSY;
            BUSY: begin
                if (annul)              state_next = IDLE;
                else if (cnt == 6'd31)  state_next = DONE;
            end
            DONE: begin
                if (accept) state_next = (b == 32'd0) ? DONE : BUSY;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo   <= 32'd0;
            dvs   <= 32'd0;
            rem   <= 32'd0;
            cnt   <= 6'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (accept) begin
            quo   <= abs_a;
            dvs   <= abs_b;
            rem   <= 32'd0;
            cnt   <= 6'd0;
            neg_q <= sign && (a[31] ^ b[31]);
            neg_r <= sign && a[31];
            // divide-by-zero skips iteration: raw dividend to hi, all-ones quotient
            if (b == 32'd0) begin
                hi <= a;
                lo <= 32'hFFFF_FFFF;
            end
        end else if (state == BUSY && !annul) begin
            quo <= quo_next;
            rem <= rem_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
                lo <= neg_q ? (~quo_next + 32'd1) : quo_next;
                hi <= neg_r ? (~rem_next + 32'd1) : rem_next;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start, sign, annul;
    logic [31:0] a, b;
    logic        stall, done;
    logic [31:0] hi, lo;

    int          tests_run = 0;
    int          failed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic [63:0] last_exp;

    div_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .annul  (annul),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // reference: {remainder, quotient} via 64-bit arithmetic, so the signed overflow case is exact
    function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        sign  = s;
        a     = x;
        b     = y;
        start = 1'b1;
    endtask

    task automatic wait_done(output int lat, output int stalls);
        lat    = 0;
        stalls = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            #1;
            lat++;
            if (stall) stalls++;
            if (done) break;
            if (lat >= 100) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; start = 1'b0; sign = 1'b0; annul = 1'b0; a = '0; b = '0;
        #3;
        tests_run++;
        if ({stall, done, hi, lo} !== 66'd0) begin
            failed++;
            $display("FAIL reset_outputs: stall=%b done=%b hi=%h lo=%h, expected all 0", stall, done, hi, lo);
        end
        start = 1'b1; b = 32'd3;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL reset_stall_with_start: stall=%b, expected 0", stall);
        end
        start = 1'b0;
    endtask

    task automatic test_divu_basic;
        int lat, st;
        @(negedge clk);
        resetn = 1'b1;
        issue(1'b0, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            failed++;
            $display("FAIL divu_stall_at_start: stall=%b, expected 1", stall);
        end
        wait_done(lat, st);
        tests_run++;
        if (lat != 33 || st != 32) begin
            failed++;
            $display("FAIL divu_latency: lat=%0d stall_cycles=%0d, expected 33 and 32", lat, st);
        end
        exp_v = exp_q.pop_front(); last_exp = exp_v;
        tests_run++;
        if ({hi, lo} !== exp_v) begin
            failed++;
            $display("FAIL divu_result: hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, exp_v[63:32], exp_v[31:0]);
        end
        @(negedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || stall !== 1'b0 || {hi, lo} !== last_exp) begin
            failed++;
            $display("FAIL divu_after_done: done=%b stall=%b hi=%h lo=%h, expected 0 0 and held result", done, stall, hi, lo);
        end
    endtask

    task automatic test_div_signed;
        int lat, st;
        logic [31:0] av[3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
        logic [31:0] bv[3] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [63:0] ev[3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000}, {32'd1, 32'hFFFF_FFFD}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(1'b1, av[i], bv[i]);
            exp_q.push_back(ev[i]);
            wait_done(lat, st);
            exp_v = exp_q.pop_front(); last_exp = exp_v;
            tests_run++;
            if (lat != 33 || {hi, lo} !== exp_v) begin
                failed++;
                $display("FAIL div_signed_%0d: lat=%0d hi=%h lo=%h, expected lat=33 hi=%h lo=%h", i, lat, hi, lo, exp_v[63:32], exp_v[31:0]);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat, st;
        @(negedge clk);
        issue(1'b0, 32'd5, 32'd0);
        exp_q.push_back({32'd5, 32'hFFFF_FFFF});
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            failed++;
            $display("FAIL divzero_stall_at_start: stall=%b, expected 1", stall);
        end
        wait_done(lat, st);
        exp_v = exp_q.pop_front(); last_exp = exp_v;
        tests_run++;
        if (lat != 1 || st != 0 || {hi, lo} !== exp_v) begin
            failed++;
            $display("FAIL divzero_unsigned: lat=%0d stalls=%0d hi=%h lo=%h, expected lat=1 stalls=0 hi=%h lo=%h", lat, st, hi, lo, exp_v[63:32], exp_v[31:0]);
        end
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FFF9, 32'd0);
        exp_q.push_back({32'hFFFF_FFF9, 32'hFFFF_FFFF});
        wait_done(lat, st);
        exp_v = exp_q.pop_front(); last_exp = exp_v;
        tests_run++;
        if (lat != 1 || {hi, lo} !== exp_v) begin
            failed++;
            $display("FAIL divzero_signed: lat=%0d hi=%h lo=%h, expected lat=1 hi=%h lo=%h", lat, hi, lo, exp_v[63:32], exp_v[31:0]);
        end
    endtask

    task automatic test_annul;
        int dones;
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        annul = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL annul_stall_drop: stall=%b, expected 0", stall);
        end
        dones = 0;
        @(negedge clk);
        annul = 1'b0;
        repeat (40) begin
            #1;
            if (done || stall) dones++;
            @(negedge clk);
        end
        tests_run++;
        if (dones != 0 || {hi, lo} !== last_exp) begin
            failed++;
            $display("FAIL annul_busy: done/stall cycles=%0d hi=%h lo=%h, expected 0 and hi=%h lo=%h", dones, hi, lo, last_exp[63:32], last_exp[31:0]);
        end
        issue(1'b0, 32'd9, 32'd3);
        annul = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL annul_with_start_stall: stall=%b, expected 0", stall);
        end
        dones = 0;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        repeat (40) begin
            #1;
            if (done || stall) dones++;
            @(negedge clk);
        end
        tests_run++;
        if (dones != 0 || {hi, lo} !== last_exp) begin
            failed++;
            $display("FAIL annul_with_start: done/stall cycles=%0d hi=%h lo=%h, expected 0 and unchanged", dones, hi, lo);
        end
    endtask

    task automatic test_busy_start_ignored;
        int lat, st;
        issue(1'b0, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        issue(1'b0, 32'd9, 32'd3);
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            failed++;
            $display("FAIL busy_start_stall: stall=%b, expected 1", stall);
        end
        wait_done(lat, st);
        exp_v = exp_q.pop_front(); last_exp = exp_v;
        tests_run++;
        if (lat != 28 || {hi, lo} !== exp_v) begin
            failed++;
            $display("FAIL busy_start_ignored: lat=%0d hi=%h lo=%h, expected lat=28 hi=%h lo=%h", lat, hi, lo, exp_v[63:32], exp_v[31:0]);
        end
    endtask

    task automatic test_reset_midop;
        int lat, st;
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (20) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        resetn = 1'b0;
        #1;
        tests_run++;
        if ({stall, done, hi, lo} !== 66'd0) begin
            failed++;
            $display("FAIL reset_midop: stall=%b done=%b hi=%h lo=%h, expected all 0", stall, done, hi, lo);
        end
        @(negedge clk);
        resetn = 1'b1;
        issue(1'b0, 32'd9, 32'd3);
        exp_q.push_back({32'd0, 32'd3});
        wait_done(lat, st);
        exp_v = exp_q.pop_front(); last_exp = exp_v;
        tests_run++;
        if (lat != 33 || {hi, lo} !== exp_v) begin
            failed++;
            $display("FAIL reset_then_divu: lat=%0d hi=%h lo=%h, expected lat=33 hi=%h lo=%h", lat, hi, lo, exp_v[63:32], exp_v[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        int lat, st;
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        exp_q.push_back(model(1'b1, 32'hFFFF_FF9C, 32'd7));
        wait_done(lat, st);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (lat != 33 || {hi, lo} !== exp_v) begin
            failed++;
            $display("FAIL b2b_first: lat=%0d hi=%h lo=%h, expected lat=33 hi=%h lo=%h", lat, hi, lo, exp_v[63:32], exp_v[31:0]);
        end
        issue(1'b0, 32'hFFFF_FFFF, 32'h10);
        exp_q.push_back({32'hF, 32'h0FFF_FFFF});
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            failed++;
            $display("FAIL b2b_stall_in_done: stall=%b, expected 1", stall);
        end
        wait_done(lat, st);
        exp_v = exp_q.pop_front(); last_exp = exp_v;
        tests_run++;
        if (lat != 33 || {hi, lo} !== exp_v) begin
            failed++;
            $display("FAIL b2b_second: lat=%0d hi=%h lo=%h, expected lat=33 hi=%h lo=%h", lat, hi, lo, exp_v[63:32], exp_v[31:0]);
        end
    endtask

    task automatic test_random;
        int lat, st;
        logic        s;
        logic [31:0] x, y;
        for (int i = 0; i < 10; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i % 4 == 1) y = {{16{y[15]}}, y[15:0]};
            @(negedge clk);
            issue(s, x, y);
            exp_q.push_back(model(s, x, y));
            wait_done(lat, st);
            exp_v = exp_q.pop_front();
            tests_run++;
            if (lat != ((y == 32'd0) ? 1 : 33) || {hi, lo} !== exp_v) begin
                failed++;
                $display("FAIL random_%0d: s=%b a=%h b=%h lat=%0d hi=%h lo=%h, expected hi=%h lo=%h", i, s, x, y, lat, hi, lo, exp_v[63:32], exp_v[31:0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_divu_basic;
        test_div_signed;
        test_div_zero;
        test_annul;
        test_busy_start_ignored;
        test_reset_midop;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
